// File: rtl/femul_digit_if.sv
`default_nettype none
// ============================================================================
// Module      : femul_digit_if
// Description : Request/result bundle for the femul_digit field multiplier.
//               The requester drives start/a/b; the multiplier returns
//               busy/done/out.
// Revision    : 1.0 - initial release
// ============================================================================
interface femul_digit_if;
    logic         start;
    logic [254:0] a;
    logic [254:0] b;
    logic         busy;
    logic         done;
    logic [254:0] out;

    modport master (output start, output a, output b,
                    input  busy,  input  done, input out);
    modport slave  (input  start, input  a, input  b,
                    output busy,  output done, output out);
endinterface : femul_digit_if
`default_nettype wire

// File: rtl/femul_digit.sv
`default_nettype none
// ============================================================================
// Module      : femul_digit
// Description : Digit-serial multiplier over GF(2^255-19). Consumes DIGIT
//               bits of the multiplier per cycle, MSB first, and folds the
//               accumulator modulo p every cycle. Operands are latched at
//               start; a one-cycle done pulse marks a new result on out.
//               Optional macro FEMUL_CANONICAL_EN adds a final cycle that
//               reduces the result into [0, p).
// Revision    : 1.0 - initial release
// ============================================================================
module femul_digit #(
    parameter int DIGIT = 5
) (
    input  wire logic     clock,
    input  wire logic     reset_n,
    femul_digit_if.slave  bus
);

    localparam int STEPS = (255 + DIGIT - 1) / DIGIT;
    localparam int RBW   = STEPS * DIGIT;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int SW    = 256 + DIGIT;

    // p = 2^255 - 19
    localparam logic [254:0] P_MOD = {{250{1'b1}}, 5'b01101};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [254:0]     ra_q,    ra_d;
    logic [RBW-1:0]   rb_q,    rb_d;
    logic [254:0]     acc_q,   acc_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [254:0]     out_q,   out_d;
    logic             done_q,  done_d;

    logic [DIGIT-1:0] w_dig;
    logic [SW-1:0]    w_prod;
    logic [SW-1:0]    w_s;
    logic [DIGIT:0]   w_hi;
    logic [DIGIT+5:0] w_hi19;
    logic [255:0]     w_t;
    logic [254:0]     w_acc;
    logic             w_last;

    // One multiply step: shift-accumulate the next digit, then fold the
    // bits at and above 2^255 back in with weight 19 (2^255 == 19 mod p).
    // The second fold absorbs the single carry the first one can create.
    always_comb begin
        w_dig  = rb_q[RBW-1 -: DIGIT];
        w_prod = SW'(ra_q) * SW'(w_dig);
        w_s    = {1'b0, acc_q, {DIGIT{1'b0}}} + w_prod;
        w_hi   = w_s[SW-1:255];
        w_hi19 = (DIGIT+6)'(w_hi) * (DIGIT+6)'(19);
        w_t    = {1'b0, w_s[254:0]} + 256'(w_hi19);
        w_acc  = w_t[254:0] + (w_t[255] ? 255'd19 : 255'd0);
        w_last = (cnt_q == CW'(STEPS - 1));
    end

`ifdef FEMUL_CANONICAL_EN
    logic         w_ge;
    logic [254:0] w_sub;

    // Accumulator is below 2^255 < 2p, so one conditional subtract suffices.
    always_comb begin
        w_ge  = (acc_q >= P_MOD);
        w_sub = acc_q - P_MOD;
    end
`endif

    // Next-state and datapath control; done defaults low so it pulses.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = RBW'(bus.b);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                acc_d = w_acc;
                rb_d  = rb_q << DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (w_last) begin
`ifdef FEMUL_CANONICAL_EN
                    state_d = ST_FIN;
`else
                    out_d   = w_acc;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef FEMUL_CANONICAL_EN
            ST_FIN: begin
                out_d   = w_ge ? w_sub : acc_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.out  = out_q;

endmodule : femul_digit
`default_nettype wire

// File: tb/tb_femul_digit.sv
`default_nettype none
// ============================================================================
// Module      : tb_femul_digit
// Description : Self-checking bench for femul_digit. Three instances
//               (DIGIT = 5, 1, 32); expected products are queued at issue
//               and compared when done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_femul_digit;

`ifdef FEMUL_CANONICAL_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int L5  = 51  + EXTRA;
    localparam int L1  = 255 + EXTRA;
    localparam int L32 = 8   + EXTRA;

    localparam logic [255:0] PW  = {1'b0, {250{1'b1}}, 5'b01101};
    localparam logic [254:0] P   = {{250{1'b1}}, 5'b01101};

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;
    logic [254:0] sbq[$];

    femul_digit_if bus5();
    femul_digit_if bus1();
    femul_digit_if bus32();

    femul_digit #(.DIGIT(5))  u5  (.clock(clock), .reset_n(reset_n), .bus(bus5));
    femul_digit #(.DIGIT(1))  u1  (.clock(clock), .reset_n(reset_n), .bus(bus1));
    femul_digit #(.DIGIT(32)) u32 (.clock(clock), .reset_n(reset_n), .bus(bus32));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [254:0] obs, input logic [254:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: bitwise double-and-add modulo p.
    function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
        logic [255:0] r;
        logic [255:0] am;
        am = {1'b0, x};
        if (am >= PW) am = am - PW;
        r = '0;
        for (int i = 254; i >= 0; i--) begin
            r = r << 1;
            if (r >= PW) r = r - PW;
            if (y[i]) begin
                r = r + am;
                if (r >= PW) r = r - PW;
            end
        end
        return r[254:0];
    endfunction

    function automatic logic [254:0] canon(input logic [254:0] x);
`ifdef FEMUL_CANONICAL_EN
        return x;
`else
        return (x >= P) ? x - P : x;
`endif
    endfunction

    function automatic logic get_busy(input int u);
        case (u)
            1:       return bus1.busy;
            32:      return bus32.busy;
            default: return bus5.busy;
        endcase
    endfunction

    function automatic logic get_done(input int u);
        case (u)
            1:       return bus1.done;
            32:      return bus32.done;
            default: return bus5.done;
        endcase
    endfunction

    function automatic logic [254:0] get_out(input int u);
        case (u)
            1:       return bus1.out;
            32:      return bus32.out;
            default: return bus5.out;
        endcase
    endfunction

    task automatic drive(input int u, input logic st, input logic [254:0] av, input logic [254:0] bv);
        case (u)
            1:       begin bus1.start  = st; bus1.a  = av; bus1.b  = bv; end
            32:      begin bus32.start = st; bus32.a = av; bus32.b = bv; end
            default: begin bus5.start  = st; bus5.a  = av; bus5.b  = bv; end
        endcase
    endtask

    function automatic logic [254:0] rnd255();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return r[254:0];
    endfunction

    task automatic issue(input int u, input logic [254:0] av, input logic [254:0] bv, input logic [254:0] exp);
        drive(u, 1'b1, av, bv);
        sbq.push_back(exp);
    endtask

    // Waits for done after the accepting edge, checking latency, busy and
    // the scoreboard result. Operands are scrambled right after acceptance.
    task automatic await(input int u, input int lat, input string tag, input logic mid);
        int           j;
        logic         seen;
        logic         busy_ok;
        logic [254:0] exp;
        @(negedge clock);
        drive(u, 1'b0, rnd255(), rnd255());
        j = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (!seen && j <= lat + 4) begin
            if (get_done(u)) begin
                seen = 1'b1;
            end else begin
                if (!get_busy(u)) busy_ok = 1'b0;
                if (mid && j == 10) drive(u, 1'b1, 255'd5, 255'd5);
                if (mid && j == 11) drive(u, 1'b0, 255'd5, 255'd5);
                @(negedge clock);
                j++;
            end
        end
        check({tag, " latency"}, 255'(j), 255'(lat));
        check({tag, " busy_during"}, 255'(busy_ok), 255'd1);
        check({tag, " busy_at_done"}, 255'(get_busy(u)), 255'd0);
        exp = (sbq.size() > 0) ? sbq.pop_front() : '1;
        check({tag, " out"}, canon(get_out(u)), exp);
    endtask

    task automatic idle_check(input int u, input string tag);
        @(negedge clock);
        check({tag, " done_cleared"}, 255'(get_done(u)), 255'd0);
    endtask

    initial begin
        logic [254:0] ra;
        logic [254:0] rb;
        int           ndone;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        drive(5, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        drive(32, 1'b0, '0, '0);
        repeat (3) @(negedge clock);
        check("reset busy", 255'(bus5.busy), 255'd0);
        check("reset done", 255'(bus5.done), 255'd0);
        check("reset out",  bus5.out,        255'd0);
        reset_n = 1'b1;
        @(negedge clock);

        issue(5, 255'd3, 255'd4, 255'd12);
        await(5, L5, "d5 3x4", 1'b0);
        idle_check(5, "d5 3x4");

        issue(1, 255'd3, 255'd4, 255'd12);
        await(1, L1, "d1 3x4", 1'b0);
        idle_check(1, "d1 3x4");

        issue(32, 255'd3, 255'd4, 255'd12);
        await(32, L32, "d32 3x4", 1'b0);
        idle_check(32, "d32 3x4");

        issue(5, P - 255'd1, P - 255'd1, 255'd1);
        await(5, L5, "pm1 sq", 1'b0);
        idle_check(5, "pm1 sq");

        issue(5, '1, 255'd2, 255'd36);
        await(5, L5, "noncanon", 1'b0);
        idle_check(5, "noncanon");

        issue(5, P, 255'd1, 255'd0);
        await(5, L5, "p times 1", 1'b0);
        idle_check(5, "p times 1");

        issue(5, 255'd3, 255'd4, 255'd12);
        await(5, L5, "mid start", 1'b1);
        issue(5, 255'd5, 255'd5, 255'd25);
        await(5, L5, "back2back", 1'b0);
        idle_check(5, "back2back");

        for (int k = 0; k < 2; k++) begin
            ra = rnd255();
            rb = rnd255();
            issue(5, ra, rb, mulmod(ra, rb));
            await(5, L5, "random", 1'b0);
            issue(32, rb, ra, mulmod(ra, rb));
            await(32, L32, "random d32", 1'b0);
        end
        idle_check(5, "random");

        issue(5, 255'd3, 255'd4, 255'd12);
        await(5, L5, "pre reset", 1'b0);
        drive(5, 1'b1, 255'd7, 255'd9);
        @(negedge clock);
        drive(5, 1'b0, 255'd0, 255'd0);
        repeat (19) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("abort busy", 255'(bus5.busy), 255'd0);
        check("abort done", 255'(bus5.done), 255'd0);
        check("abort out",  bus5.out,        255'd0);
        @(negedge clock);
        reset_n = 1'b1;
        ndone = 0;
        repeat (L5 + 5) begin
            @(negedge clock);
            if (bus5.done) ndone++;
        end
        check("abort no done", 255'(ndone), 255'd0);

        issue(5, 255'd3, 255'd4, 255'd12);
        await(5, L5, "after reset", 1'b0);
        idle_check(5, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_femul_digit
`default_nettype wire

// File: doc/femul_digit.md
# femul_digit

Digit-serial multiplier over GF(2^255−19) with a configurable digit width and a registered handshake. It consumes DIGIT bits of multiplier `b` per cycle, MSB first, and folds the accumulator modulo p = 2^255−19 every cycle. It succeeds the fixed-schedule `femul` as the field-multiply engine under the curve25519 ladder controller. Unlike `femul`, it latches its operands at `start`, exposes `busy`, has a reset, and can optionally emit canonical results.

## Interface
- `DIGIT`, default 5: multiplier bits consumed per cycle; legal range 1..32.
- `STEPS`, derived as ceil(255/DIGIT) and not overridable: multiply cycles per operation. Default is 51.
- `clock`  input  1  rising-edge clock for all state.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only while idle.
- `a`  input  255  multiplicand; any 255-bit value is accepted, including values ≥ p.
- `b`  input  255  multiplier; any 255-bit value is accepted.
- `busy`  output  1  high while an operation is in flight.
- `done`  output  1  one-cycle pulse marking a new result on `out`.
- `out`  output  255  product a·b mod p; held until the next result.

## Operation
- States:
  - IDLE.
  - MUL, for STEPS cycles.
  - FIN, for one cycle, present only with FEMUL_CANONICAL_EN.
- IDLE with `start`=1 at an edge:
  - latch `a` into `ra`;
  - latch `b`, zero-extended to STEPS·DIGIT bits, into shift register `rb`;
  - clear `acc`, clear `cnt`, go to MUL.
- MUL step, using `d` = the top DIGIT bits of `rb`:
  - s = acc·2^DIGIT + ra·d, width 256+DIGIT.
  - Fold 1: t = s[254:0] + 19·s[255+DIGIT:255].
  - Fold 2: acc ← t[254:0] + 19·t[255].
  - Both folds complete combinationally in the same cycle.
  - `rb` shifts left by DIGIT; `cnt` increments.
- Invariant after every step: `acc` < 2^255 and `acc` ≡ partial product (mod p). No overflow is possible for DIGIT ≤ 32.
- After step STEPS:
  - Without the macro: `out` ← `acc`, `done` ← 1, go to IDLE.
  - With the macro: go to FIN.
- FIN: `out` ← (acc ≥ p) ? acc − p : acc; `done` ← 1; go to IDLE.
- `start` while `busy`=1 is ignored; no queuing.
- `a` and `b` may change freely after the accepting edge.
- `done`=1 implies `busy`=0. `start` in the same cycle as `done` is accepted, so operations run back-to-back with no bubble.
- `out` changes only on the edge that raises `done`, or on reset.

## Timing
- Reset (`reset_n`=0, asynchronous): state=IDLE, `busy`=0, `done`=0, `out`=0, `acc`=0, `cnt`=0.
- Reset mid-operation aborts immediately. After release the block is idle, and no `done` is produced for the aborted operation.
- With `start` accepted at edge k:
  - `busy`=1 from edge k through edge k+L−1.
  - `done`=1 and `out` valid after edge k+L.
  - `done` clears at edge k+L+1 unless a new operation completes on that edge.
- Latency L = STEPS without the macro, STEPS+1 with it. For the default DIGIT=5, L is 51 or 52.
- Throughput is one result per L cycles.
- Critical path: one 255×DIGIT multiply plus two small-constant folds. DIGIT trades latency against this path.

## Configuration
- Macro `FEMUL_CANONICAL_EN`.
- Defined:
  - the FIN state exists and adds one cycle;
  - `out` is always canonical, in [0, p).
- Undefined:
  - no FIN state;
  - `out` is < 2^255 and congruent mod p, but may lie in [p, 2^255−1];
  - downstream logic must tolerate this.

## Test plan
- Basic product, for each of DIGIT=5, 1 and 32 with the macro undefined:
  - stimulus: `a`=3, `b`=4, `start` high for one cycle;
  - required: `out`=12 and `done`=1 exactly 51, 255 and 8 edges after the accepting edge respectively;
  - `busy` is high for exactly those cycles.
- Large operands: `a`=`b`=p−1 → `out`=1.
- Non-canonical inputs: `a`=2^255−1 (≡ 18), `b`=2 → `out`=36.
- Canonical output, `a`=p, `b`=1:
  - macro defined: `out`=0 after 52 edges;
  - macro undefined: `out` ∈ {0, p} after 51 edges.
- Handshake:
  - A second `start` with `a`=5 and `b`=5, issued mid-operation, is ignored: `out`=12.
  - `start` asserted in the `done` cycle with `a`=`b`=5 yields `out`=25 after L further edges.
  - `a`/`b` are changed on the cycle after acceptance, and the result is unaffected.
- Reset mid-operation:
  - `reset_n` low at step 20 → `busy`=0, `done`=0, `out`=0 asynchronously.
  - No `done` pulse follows.
  - A fresh `start` with 3×4 yields 12.
